// File: rtl/hssi_tc_mailbox_ctrl_if.sv
// Mailbox bus bundle: CSR host side plus traffic-controller access side.
// The slave modport is the mailbox controller; the master modport is the host/TC.
interface hssi_tc_mailbox_ctrl_if #(
    parameter int NUM_PORTS = 8,
    parameter int TC_ADDR_W = 16
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                 csr_we;
    logic                 csr_re;
    logic [3:0]           csr_addr;
    logic [31:0]          csr_wdata;
    logic [31:0]          csr_rdata;
    logic [PORT_W-1:0]    port_sel;
    logic                 tc_req;
    logic                 tc_wr;
    logic [PORT_W-1:0]    tc_port;
    logic [TC_ADDR_W-1:0] tc_addr;
    logic [31:0]          tc_wdata;
    logic                 tc_ack;
    logic [31:0]          tc_rdata;

    modport slave (
        input  csr_we, csr_re, csr_addr, csr_wdata, port_sel, tc_ack, tc_rdata,
        output csr_rdata, tc_req, tc_wr, tc_port, tc_addr, tc_wdata
    );

    modport master (
        output csr_we, csr_re, csr_addr, csr_wdata, port_sel, tc_ack, tc_rdata,
        input  csr_rdata, tc_req, tc_wr, tc_port, tc_addr, tc_wdata
    );
endinterface

// File: rtl/hssi_tc_mailbox_ctrl.sv
// CSR mailbox that launches one traffic-controller register access at a time,
// waits for tc_ack (or a timeout) and reports completion through STATUS.
module hssi_tc_mailbox_ctrl #(
    parameter int NUM_PORTS   = 8,
    parameter int TC_ADDR_W   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    hssi_tc_mailbox_ctrl_if.slave bus
);
    localparam int          PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [1:0]  CMD_RD  = 2'd1;
    localparam logic [1:0]  CMD_WR  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wrdata_q, wrdata_d;
    logic [31:0]          rddata_q, rddata_d;
    logic [31:0]          csr_rdata_q, csr_rdata_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic                 dropped_q, dropped_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 tc_req_q, tc_req_d;
    logic                 tc_wr_q, tc_wr_d;
    logic [PORT_W-1:0]    tc_port_q, tc_port_d;
    logic [TC_ADDR_W-1:0] tc_addr_q, tc_addr_d;
    logic [31:0]          tc_wdata_q, tc_wdata_d;

    logic       cmd_wr;
    logic       cmd_access;
    logic [1:0] cmd;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        rddata_d    = rddata_q;
        csr_rdata_d = csr_rdata_q;
        done_d      = done_q;
        busy_d      = busy_q;
        timeout_d   = timeout_q;
        dropped_d   = dropped_q;
        cnt_d       = cnt_q;
        tc_req_d    = tc_req_q;
        tc_wr_d     = tc_wr_q;
        tc_port_d   = tc_port_q;
        tc_addr_d   = tc_addr_q;
        tc_wdata_d  = tc_wdata_q;

        cmd        = bus.csr_wdata[1:0];
        cmd_wr     = bus.csr_we && (bus.csr_addr == 4'h0);
        cmd_access = (cmd == CMD_RD) || (cmd == CMD_WR);

        // Reads sample the pre-write register values, so a same-cycle write is not visible.
        if (bus.csr_re) begin
            case (bus.csr_addr)
                4'h0:    csr_rdata_d = {27'b0, dropped_q, timeout_q, busy_q, done_q, 1'b0};
                4'h4:    csr_rdata_d = addr_q;
                4'h8:    csr_rdata_d = rddata_q;
                4'hC:    csr_rdata_d = wrdata_q;
                default: csr_rdata_d = 32'h0;
            endcase
        end

        if (bus.csr_we && (bus.csr_addr == 4'h4)) addr_d   = bus.csr_wdata;
        if (bus.csr_we && (bus.csr_addr == 4'hC)) wrdata_d = bus.csr_wdata;

        if (cmd_wr && !cmd_access) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
            dropped_d = 1'b0;
        end
        if (cmd_wr && cmd_access && (state_q != S_IDLE)) dropped_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_wr && cmd_access) begin
                    tc_port_d  = bus.port_sel;
                    tc_addr_d  = addr_q[TC_ADDR_W-1:0];
                    tc_wdata_d = wrdata_q;
                    tc_wr_d    = (cmd == CMD_WR);
                    tc_req_d   = 1'b1;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    dropped_d  = 1'b0;
                    cnt_d      = 16'h0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h1;
                // An ack on the threshold cycle still completes the access normally.
                if (bus.tc_ack) begin
                    if (!tc_wr_q) rddata_d = bus.tc_rdata;
                    tc_req_d = 1'b0;
                    state_d  = S_DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    tc_req_d  = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0;
            wrdata_q    <= 32'h0;
            rddata_q    <= 32'h0;
            csr_rdata_q <= 32'h0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            dropped_q   <= 1'b0;
            cnt_q       <= 16'h0;
            tc_req_q    <= 1'b0;
            tc_wr_q     <= 1'b0;
            tc_port_q   <= '0;
            tc_addr_q   <= '0;
            tc_wdata_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
            rddata_q    <= rddata_d;
            csr_rdata_q <= csr_rdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            dropped_q   <= dropped_d;
            cnt_q       <= cnt_d;
            tc_req_q    <= tc_req_d;
            tc_wr_q     <= tc_wr_d;
            tc_port_q   <= tc_port_d;
            tc_addr_q   <= tc_addr_d;
            tc_wdata_q  <= tc_wdata_d;
        end
    end

    assign bus.csr_rdata = csr_rdata_q;
    assign bus.tc_req    = tc_req_q;
    assign bus.tc_wr     = tc_wr_q;
    assign bus.tc_port   = tc_port_q;
    assign bus.tc_addr   = tc_addr_q;
    assign bus.tc_wdata  = tc_wdata_q;
endmodule

// File: tb/tb_hssi_tc_mailbox_ctrl.sv
// Directed bench for hssi_tc_mailbox_ctrl with a transaction-level mailbox model
// compared against the DUT outputs on every cycle.
module tb_hssi_tc_mailbox_ctrl;
    localparam int NP = 8;
    localparam int AW = 16;
    localparam int TO = 16;
    localparam int PW = $clog2(NP);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hssi_tc_mailbox_ctrl_if #(.NUM_PORTS(NP), .TC_ADDR_W(AW)) bus_if ();

    hssi_tc_mailbox_ctrl #(.NUM_PORTS(NP), .TC_ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Mailbox model: registers, sticky flags, and the one access in flight.
    logic [31:0]   m_addr, m_wrdata, m_rddata, m_rd_exp;
    logic          m_done, m_timeout, m_dropped, m_rd_valid;
    logic          m_busy, m_inflight, m_tail;
    int            m_age;
    logic          m_tc_wr;
    logic [PW-1:0] m_tc_port;
    logic [AW-1:0] m_tc_addr;
    logic [31:0]   m_tc_wdata;
    int            req_rises;
    logic          prev_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_wrdata = '0; m_rddata = '0; m_rd_exp = '0;
        m_done = 0; m_timeout = 0; m_dropped = 0; m_rd_valid = 0;
        m_busy = 0; m_inflight = 0; m_tail = 0; m_age = 0;
        m_tc_wr = 0; m_tc_port = '0; m_tc_addr = '0; m_tc_wdata = '0;
    endtask

    function automatic logic [31:0] read_val(input logic [3:0] a);
        case (a)
            4'h0:    return {27'b0, m_dropped, m_timeout, m_busy, m_done, 1'b0};
            4'h4:    return m_addr;
            4'h8:    return m_rddata;
            4'hC:    return m_wrdata;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic       pre_busy, pre_infl, pre_tail;
        logic [1:0] cmd;
        if (rst) begin
            model_reset();
            return;
        end
        m_rd_valid = bus_if.csr_re;
        if (bus_if.csr_re) m_rd_exp = read_val(bus_if.csr_addr);
        pre_busy = m_busy;
        pre_infl = m_inflight;
        pre_tail = m_tail;
        cmd = bus_if.csr_wdata[1:0];
        if (bus_if.csr_we) begin
            case (bus_if.csr_addr)
                4'h0: begin
                    if (cmd == 2'd1 || cmd == 2'd2) begin
                        if (pre_busy) m_dropped = 1;
                        else begin
                            m_busy = 1; m_inflight = 1; m_age = 0;
                            m_tc_wr = (cmd == 2'd2);
                            m_tc_port = bus_if.port_sel;
                            m_tc_addr = m_addr[AW-1:0];
                            m_tc_wdata = m_wrdata;
                            m_done = 0; m_timeout = 0; m_dropped = 0;
                        end
                    end else begin
                        m_done = 0; m_timeout = 0; m_dropped = 0;
                    end
                end
                4'h4: m_addr = bus_if.csr_wdata;
                4'hC: m_wrdata = bus_if.csr_wdata;
                default: ;
            endcase
        end
        if (pre_tail) begin
            m_done = 1; m_busy = 0; m_tail = 0;
        end
        if (pre_infl) begin
            if (bus_if.tc_ack) begin
                if (!m_tc_wr) m_rddata = bus_if.tc_rdata;
                m_inflight = 0; m_tail = 1;
            end else if (m_age == TO - 1) begin
                m_timeout = 1; m_inflight = 0; m_tail = 1;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic compare_cycle();
        check("tc_req", 32'(bus_if.tc_req), 32'(m_inflight));
        check("tc_wr", 32'(bus_if.tc_wr), 32'(m_tc_wr));
        check("tc_port", 32'(bus_if.tc_port), 32'(m_tc_port));
        check("tc_addr", 32'(bus_if.tc_addr), 32'(m_tc_addr));
        check("tc_wdata", bus_if.tc_wdata, m_tc_wdata);
        if (m_rd_valid) check("csr_rdata", bus_if.csr_rdata, m_rd_exp);
        if (bus_if.tc_req && !prev_req) req_rises++;
        prev_req = bus_if.tc_req;
    endtask

    // One clock: compare on the falling edge, advance the model on the rising edge.
    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic csr_op(input logic we, input logic re, input logic [3:0] a, input logic [31:0] d);
        bus_if.csr_we = we; bus_if.csr_re = re; bus_if.csr_addr = a; bus_if.csr_wdata = d;
        tick();
        bus_if.csr_we = 0; bus_if.csr_re = 0; bus_if.csr_addr = 4'h0; bus_if.csr_wdata = '0;
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        csr_op(1'b1, 1'b0, a, d);
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
        csr_op(1'b0, 1'b1, a, 32'h0);
        d = bus_if.csr_rdata;
    endtask

    // Ack lands in the n-th REQ cycle when called right after the launching write.
    task automatic ack_after(input int n, input logic [31:0] rdata);
        idle(n - 1);
        bus_if.tc_ack = 1; bus_if.tc_rdata = rdata;
        tick();
        bus_if.tc_ack = 0; bus_if.tc_rdata = '0;
    endtask

    initial begin
        logic [31:0] d;
        int          cnt;
        int          rises0;

        rst = 1;
        bus_if.csr_we = 0; bus_if.csr_re = 0; bus_if.csr_addr = 4'h0; bus_if.csr_wdata = '0;
        bus_if.port_sel = '0; bus_if.tc_ack = 0; bus_if.tc_rdata = '0;
        prev_req = 0; req_rises = 0;
        model_reset();
        idle(2);
        rst = 0;
        tick();

        // Reset state
        check("reset_tc_req", 32'(bus_if.tc_req), 32'h0);
        csr_read(4'h0, d); check("reset_status", d, 32'h0);

        // Read access to port 2, ack in 5th REQ cycle
        csr_write(4'h4, 32'h0000_0009);
        bus_if.port_sel = 3'd2;
        csr_write(4'h0, 32'h1);
        check("rd_tc_req", 32'(bus_if.tc_req), 32'h1);
        check("rd_tc_port", 32'(bus_if.tc_port), 32'h2);
        check("rd_tc_addr", 32'(bus_if.tc_addr), 32'h9);
        check("rd_tc_wr", 32'(bus_if.tc_wr), 32'h0);
        ack_after(5, 32'h0000_0040);
        idle(2);
        csr_read(4'h8, d); check("rd_rddata", d, 32'h40);
        csr_read(4'h0, d); check("rd_status", d, 32'h2);

        // Write access, ack in 1st REQ cycle
        csr_write(4'hC, 32'h0000_0001);
        csr_write(4'h4, 32'h0000_0003);
        csr_write(4'h0, 32'h2);
        check("wr_tc_wr", 32'(bus_if.tc_wr), 32'h1);
        check("wr_tc_wdata", bus_if.tc_wdata, 32'h1);
        check("wr_tc_addr", 32'(bus_if.tc_addr), 32'h3);
        ack_after(1, 32'hBAD0_BAD0);
        idle(2);
        csr_read(4'h8, d); check("wr_rddata_kept", d, 32'h40);
        csr_read(4'h0, d); check("wr_status", d, 32'h2);

        // Timeout with no ack
        csr_write(4'h0, 32'h1);
        cnt = 0;
        while (bus_if.tc_req && cnt < 100) begin
            cnt++;
            tick();
        end
        check("to_req_cycles", 32'(cnt), 32'd16);
        idle(2);
        csr_read(4'h0, d); check("to_status", d, 32'hA);
        csr_read(4'h8, d); check("to_rddata_kept", d, 32'h40);

        // Command while busy is dropped; address update while busy does not reach tc_addr
        rises0 = req_rises;
        csr_write(4'h4, 32'h0000_0055);
        csr_write(4'h0, 32'h1);
        csr_write(4'h4, 32'h0000_0066);
        csr_write(4'h0, 32'h2);
        check("drop_tc_addr", 32'(bus_if.tc_addr), 32'h55);
        check("drop_tc_wr", 32'(bus_if.tc_wr), 32'h0);
        ack_after(1, 32'h0000_0077);
        idle(3);
        check("drop_one_access", 32'(req_rises - rises0), 32'd1);
        csr_read(4'h0, d); check("drop_status", d, 32'h12);
        csr_read(4'h8, d); check("drop_rddata", d, 32'h77);
        csr_read(4'h4, d); check("drop_address", d, 32'h66);
        csr_write(4'h0, 32'h0);
        csr_read(4'h0, d); check("noop_status", d, 32'h0);

        // Reset in the middle of REQ, then a stray ack
        csr_write(4'h0, 32'h1);
        tick();
        rst = 1;
        #1;
        model_reset();
        check("rst_tc_req_async", 32'(bus_if.tc_req), 32'h0);
        tick();
        rst = 0;
        bus_if.tc_ack = 1; bus_if.tc_rdata = 32'h0000_0099;
        tick();
        bus_if.tc_ack = 0; bus_if.tc_rdata = '0;
        idle(2);
        csr_read(4'h0, d); check("rst_status", d, 32'h0);
        csr_read(4'h8, d); check("rst_rddata", d, 32'h0);

        // Ack on the timeout threshold cycle wins
        csr_write(4'h0, 32'h1);
        ack_after(16, 32'h1234_5678);
        idle(2);
        csr_read(4'h0, d); check("edge_status", d, 32'h2);
        csr_read(4'h8, d); check("edge_rddata", d, 32'h1234_5678);

        // Register-file corner cases
        csr_read(4'h2, d); check("undef_0x2", d, 32'h0);
        csr_read(4'h1, d); check("undef_0x1", d, 32'h0);
        csr_write(4'h8, 32'hDEAD_BEEF);
        csr_read(4'h8, d); check("rddata_ro", d, 32'h1234_5678);
        csr_write(4'h4, 32'h0000_1111);
        csr_op(1'b1, 1'b1, 4'h4, 32'h0000_2222);
        check("rw_same_cycle", bus_if.csr_rdata, 32'h1111);
        csr_read(4'h4, d); check("rw_new_value", d, 32'h2222);
        bus_if.tc_ack = 1; bus_if.tc_rdata = 32'hFFFF_FFFF;
        tick();
        bus_if.tc_ack = 0; bus_if.tc_rdata = '0;
        csr_read(4'h8, d); check("idle_ack_ignored", d, 32'h1234_5678);
        csr_write(4'h0, 32'h3);
        check("rsvd_no_req", 32'(bus_if.tc_req), 32'h0);
        csr_read(4'h0, d); check("rsvd_clears", d, 32'h0);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hssi_tc_mailbox_ctrl.md
HSSI_TC_MAILBOX_CTRL -- requirements
Module: hssi_tc_mailbox_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 8: number of traffic-controller ports.
REQ-002 SHALL have parameter TC_ADDR_W, default 16: traffic-controller register address width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024: cycles to wait for tc_ack before abort.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port csr_we, input, 1: mailbox register write strobe.
REQ-007 SHALL have port csr_re, input, 1: mailbox register read strobe.
REQ-008 SHALL have port csr_addr, input, 4: byte offset; 0x0 CMD/STATUS, 0x4 ADDRESS, 0x8 RDDATA, 0xC WRDATA.
REQ-009 SHALL have port csr_wdata, input, 32: write data.
REQ-010 SHALL have port csr_rdata, output, 32: read data, valid 1 cycle after csr_re.
REQ-011 SHALL have port port_sel, input, $clog2(NUM_PORTS): target port, sampled at CMD launch.
REQ-012 SHALL have port tc_req, output, 1: traffic-controller access request.
REQ-013 SHALL have port tc_wr, output, 1: 1 = write, 0 = read; valid while tc_req.
REQ-014 SHALL have port tc_port, output, $clog2(NUM_PORTS): latched target port.
REQ-015 SHALL have port tc_addr, output, TC_ADDR_W: ADDRESS[TC_ADDR_W-1:0].
REQ-016 SHALL have port tc_wdata, output, 32: WRDATA snapshot.
REQ-017 SHALL have port tc_ack, input, 1: access complete; single-cycle pulse.
REQ-018 SHALL have port tc_rdata, input, 32: read data, valid with tc_ack.

Function
REQ-019 SHALL decode CMD = csr_wdata[1:0] at offset 0x0: 0 NOOP, 1 RD, 2 WR, 3 reserved (treated as NOOP).
REQ-020 SHALL read STATUS at 0x0 as {27'b0, dropped, timeout, busy, done, 1'b0}, i.e. bit1 done, bit2 busy, bit3 timeout, bit4 dropped.
REQ-021 SHALL make ADDRESS and WRDATA read/write; RDDATA is read-only, and writes to it are ignored.
REQ-022 SHALL run the FSM IDLE -> REQ -> DONE -> IDLE.
REQ-023 In IDLE, a RD/WR write to CMD SHALL latch port_sel, ADDRESS and WRDATA; clear done, timeout and dropped; set busy; and enter REQ, with tc_req high on the next cycle.
REQ-024 SHALL hold tc_req and all tc_* outputs stable in REQ until the cycle in which tc_ack=1.
REQ-025 On tc_ack in REQ, SHALL capture tc_rdata into RDDATA (RD only; WR leaves RDDATA unchanged), deassert tc_req next cycle, and enter DONE.
REQ-026 In REQ, a 16-bit-saturating timeout counter SHALL increment each cycle; at count TIMEOUT_CYC-1 without tc_ack it SHALL set timeout, leave RDDATA unchanged, and enter DONE.
REQ-027 A tc_ack arriving in the same cycle as the timeout threshold SHALL win: no timeout is flagged.
REQ-028 DONE SHALL last 1 cycle, set done, clear busy, and return to IDLE.
REQ-029 tc_ack outside REQ SHALL be ignored.
REQ-030 A RD/WR CMD write while busy SHALL be ignored and SHALL set dropped (sticky until next accepted launch or NOOP).
REQ-031 A NOOP write SHALL clear done, timeout and dropped in any state without aborting an access in flight.
REQ-032 A write to ADDRESS/WRDATA while busy SHALL update the register but not the latched tc_* values.
REQ-033 Simultaneous csr_we and csr_re SHALL both take effect; the read returns the pre-write value.
REQ-034 Reads of undefined offsets SHALL return 0.
REQ-035 The csr_we -> tc_req latency SHALL be 1 cycle, and tc_ack -> done visible in STATUS SHALL be 2 cycles.

Reset
REQ-036 On rst, SHALL go asynchronously to IDLE with tc_req=0, tc_wr=0, tc_port=0, tc_addr=0, tc_wdata=0, csr_rdata=0, all mailbox registers 0, status bits 0, and the timeout counter 0.
REQ-037 rst during REQ SHALL drop tc_req immediately; a subsequent tc_ack SHALL be ignored.

Verification
REQ-038 Write ADDRESS=0x0009, port_sel=2, CMD=RD; ack after 5 cycles with tc_rdata=0x0000_0040 -> tc_port=2, tc_addr=0x0009, tc_wr=0, RDDATA=0x40, STATUS=0x2.
REQ-039 WRDATA=0x0000_0001, ADDRESS=0x0003, CMD=WR, ack after 1 cycle -> tc_wr=1, tc_wdata=1, RDDATA unchanged, STATUS=0x2.
REQ-040 TIMEOUT_CYC=16, CMD=RD, no ack -> tc_req high exactly 16 cycles, then STATUS=0xA (done and timeout), RDDATA unchanged.
REQ-041 CMD=RD, then CMD=WR while busy, then ack -> only one access is issued, STATUS=0x12 (done and dropped); NOOP then reads STATUS=0x0.
REQ-042 Assert rst 2 cycles into REQ, then pulse tc_ack -> tc_req=0 the same cycle, STATUS=0, RDDATA=0.
REQ-043 With TIMEOUT_CYC=16, tc_ack in the 16th REQ cycle -> STATUS=0x2, no timeout.
